// File: rtl/snoop_listener_array.sv
// Purpose: snooping coherence listener over a direct-mapped line array (MSI; MESI with SNOOP_MESI_EXCLUSIVE_EN).
// Latency: snoop_done 2 cycles after bus acceptance, plus the writeback cycles on a Modified hit.
// Backpressure: bus_ready only in IDLE; writeback holds wb_* stable until wb_ready is sampled high.
module snoop_listener_array #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2,
    parameter int DATA_W  = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [1:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_state,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              abort_mem,
    output logic              snoop_done,
    output logic              snoop_hit,
    output logic [1:0]        line_state
);
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int TAG_W     = ADDR_W - INDEX_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;
    localparam logic [1:0] ST_E = 2'b11;

    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, UPDATE} fsm_t;

    fsm_t fsm_q, fsm_d;

    logic [1:0]        line_st  [NUM_LINES];
    logic [TAG_W-1:0]  line_tag [NUM_LINES];
    logic [DATA_W-1:0] line_dat [NUM_LINES];

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              hit_q;
    logic [1:0]        pre_q;
    logic              wbd_q;

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [1:0]        pend_st;
    logic [DATA_W-1:0] pend_dat;

    logic [INDEX_W-1:0] s_idx;
    logic [INDEX_W-1:0] c_idx;
    logic [INDEX_W-1:0] p_idx;
    logic               lk_hit;
    logic               cpu_conflict;
    logic [1:0]         cpu_st_eff;

    // Exclusive encoding is only meaningful in the MESI build; elsewhere it collapses to Invalid.
    function automatic logic [1:0] coerce_state(input logic [1:0] s);
`ifdef SNOOP_MESI_EXCLUSIVE_EN
        return s;
`else
        return (s == ST_E) ? ST_I : s;
`endif
    endfunction

    assign s_idx        = addr_q[INDEX_W-1:0];
    assign c_idx        = cpu_addr[INDEX_W-1:0];
    assign p_idx        = pend_addr[INDEX_W-1:0];
    assign lk_hit       = (line_tag[s_idx] == addr_q[ADDR_W-1:INDEX_W]) && (line_st[s_idx] != ST_I);
    assign cpu_conflict = cpu_we && (fsm_q != IDLE) && (c_idx == s_idx);
    assign cpu_st_eff   = coerce_state(cpu_state);

    // Snoop FSM state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) fsm_q <= IDLE;
        else         fsm_q <= fsm_d;
    end

    // Next-state and handshake outputs; all outputs derive from registered state so reset clears them at once.
    always_comb begin
        fsm_d      = fsm_q;
        bus_ready  = 1'b0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        abort_mem  = 1'b0;
        snoop_done = 1'b0;
        snoop_hit  = 1'b0;
        line_state = ST_I;
        case (fsm_q)
            IDLE: begin
                bus_ready = 1'b1;
                if (bus_valid && bus_op != 2'b00) fsm_d = LOOKUP;
            end
            LOOKUP: begin
                // Invalidate against M is illegal; the line simply drops without a writeback.
                if (lk_hit && line_st[s_idx] == ST_M && op_q != OP_INV) fsm_d = WRITEBACK;
                else                                                   fsm_d = UPDATE;
            end
            WRITEBACK: begin
                wb_valid  = 1'b1;
                abort_mem = 1'b1;
                wb_addr   = addr_q;
                wb_data   = line_dat[s_idx];
                if (wb_ready) fsm_d = UPDATE;
            end
            UPDATE: begin
                snoop_done = 1'b1;
                snoop_hit  = hit_q;
                line_state = pre_q;
`ifdef SNOOP_MESI_EXCLUSIVE_EN
                abort_mem  = wbd_q || (hit_q && pre_q == ST_E && op_q == OP_RD);
`else
                abort_mem  = wbd_q;
`endif
                fsm_d      = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Latch the accepted transaction and the lookup result for the UPDATE cycle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            op_q   <= 2'b00;
            addr_q <= '0;
            hit_q  <= 1'b0;
            pre_q  <= ST_I;
            wbd_q  <= 1'b0;
        end else begin
            if (fsm_q == IDLE && bus_valid && bus_op != 2'b00) begin
                op_q   <= bus_op;
                addr_q <= bus_addr;
                wbd_q  <= 1'b0;
            end
            if (fsm_q == LOOKUP) begin
                hit_q <= lk_hit;
                pre_q <= line_st[s_idx];
            end
            if (fsm_q == WRITEBACK && wb_ready) wbd_q <= 1'b1;
        end
    end

    // Line array: snoop downgrade, deferred CPU write (first IDLE cycle), then live CPU writes.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_st[i]  <= ST_I;
                line_tag[i] <= '0;
                line_dat[i] <= '0;
            end
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_st   <= ST_I;
            pend_dat  <= '0;
        end else begin
            // Any snooped hit ends as S for a read miss, otherwise I.
            if (fsm_q == UPDATE && hit_q)
                line_st[s_idx] <= (op_q == OP_RD) ? ST_S : ST_I;
            if (fsm_q == IDLE && pend_vld) begin
                pend_vld        <= 1'b0;
                line_st[p_idx]  <= pend_st;
                line_tag[p_idx] <= pend_addr[ADDR_W-1:INDEX_W];
                line_dat[p_idx] <= pend_dat;
            end
            if (cpu_conflict) begin
                // Only the latest conflicting write is kept.
                pend_vld  <= 1'b1;
                pend_addr <= cpu_addr;
                pend_st   <= cpu_st_eff;
                pend_dat  <= cpu_data;
            end else if (cpu_we) begin
                line_st[c_idx]  <= cpu_st_eff;
                line_tag[c_idx] <= cpu_addr[ADDR_W-1:INDEX_W];
                line_dat[c_idx] <= cpu_data;
            end
        end
    end

endmodule

// File: tb/tb_snoop_listener_array.sv
module tb_snoop_listener_array;
    logic       Clock;
    logic       Resetn;
    logic       bus_valid;
    logic       bus_ready;
    logic [1:0] bus_op;
    logic [7:0] bus_addr;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [1:0] cpu_state;
    logic [7:0] cpu_data;
    logic       wb_valid;
    logic       wb_ready;
    logic [7:0] wb_addr;
    logic [7:0] wb_data;
    logic       abort_mem;
    logic       snoop_done;
    logic       snoop_hit;
    logic [1:0] line_state;

    snoop_listener_array #(.ADDR_W(8), .INDEX_W(2), .DATA_W(8)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_state(cpu_state), .cpu_data(cpu_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .abort_mem(abort_mem), .snoop_done(snoop_done), .snoop_hit(snoop_hit), .line_state(line_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    bit mesi;

    // Reference cache: state/tag/data per line.
    logic [1:0] mst  [4];
    logic [5:0] mtag [4];
    logic [7:0] mdat [4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mst[i] = 2'b00; mtag[i] = 6'd0; mdat[i] = 8'd0;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [1:0] s, input logic [7:0] d);
        logic [1:0] se;
        se = (!mesi && s == 2'b11) ? 2'b00 : s;
        mst[a[1:0]]  = se;
        mtag[a[1:0]] = a[7:2];
        mdat[a[1:0]] = d;
    endtask

    // Called at a negedge with idle inputs; returns at a negedge.
    task automatic cpu_write(input logic [7:0] a, input logic [1:0] s, input logic [7:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_state = s; cpu_data = d;
        @(negedge Clock);
        cpu_we = 1'b0;
        model_write(a, s, d);
    endtask

    // One snoop: wb_ready low for cycles 1..low after acceptance; optional CPU write in cycle cn.
    task automatic do_snoop(input logic [1:0] op, input logic [7:0] addr, input int low,
                            input int cn, input logic [7:0] caddr, input logic [1:0] cst,
                            input logic [7:0] cdat,
                            output logic ohit, output logic [1:0] ols, output int olat);
        int         idx;
        logic       ehit, ewb, eab, deferred;
        logic [1:0] els;
        logic [7:0] edat;
        int         elat;
        idx  = int'(addr[1:0]);
        ehit = (mtag[idx] == addr[7:2]) && (mst[idx] != 2'b00);
        els  = mst[idx];
        edat = mdat[idx];
        ewb  = ehit && els == 2'b10 && op != 2'b11;
        eab  = ewb || (mesi && ehit && els == 2'b11 && op == 2'b01);
        elat = ewb ? low + 2 : 2;
        deferred = 1'b0;
        ohit = 1'bx; ols = 2'bxx; olat = -1;
        bus_valid = 1'b1; bus_op = op; bus_addr = addr;
        check_val("accept_ready", bus_ready, 1);
        for (int n = 1; n <= elat; n++) begin
            @(negedge Clock);
            bus_valid = 1'b0; bus_op = 2'b00;
            cpu_we = 1'b0;
            wb_ready = (n > low);
            if (n == cn) begin
                cpu_we = 1'b1; cpu_addr = caddr; cpu_state = cst; cpu_data = cdat;
                if (int'(caddr[1:0]) == idx) deferred = 1'b1;
                else model_write(caddr, cst, cdat);
            end
            check_val("done_timing", snoop_done, (n == elat));
            check_val("wb_valid", wb_valid, ewb && n >= 2 && n < elat);
            if (ewb && n >= 2 && n < elat) begin
                check_val("wb_addr", wb_addr, addr);
                check_val("wb_data", wb_data, edat);
                check_val("abort_wb", abort_mem, 1);
            end else if (n == 1) begin
                check_val("abort_lookup", abort_mem, 0);
            end
            if (snoop_done === 1'b1) begin
                ohit = snoop_hit; ols = line_state; olat = n;
            end
            if (n == elat) begin
                check_val("snoop_hit", snoop_hit, ehit);
                check_val("line_state", line_state, els);
                check_val("abort_update", abort_mem, eab);
            end
        end
        @(negedge Clock);
        cpu_we = 1'b0; wb_ready = 1'b0;
        check_val("idle_ready", bus_ready, 1);
        check_val("idle_done", snoop_done, 0);
        if (ehit) mst[idx] = (op == 2'b01) ? 2'b01 : 2'b00;
        if (deferred) model_write(caddr, cst, cdat);
    endtask

    logic       h;
    logic [1:0] ls;
    int         lat;

    initial begin
`ifdef SNOOP_MESI_EXCLUSIVE_EN
        mesi = 1'b1;
`else
        mesi = 1'b0;
`endif
        Resetn = 1'b0; bus_valid = 1'b0; bus_op = 2'b00; bus_addr = 8'd0;
        cpu_we = 1'b0; cpu_addr = 8'd0; cpu_state = 2'b00; cpu_data = 8'd0; wb_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check_val("rst_ready", bus_ready, 1);
        check_val("rst_wb_valid", wb_valid, 0);
        check_val("rst_abort", abort_mem, 0);
        check_val("rst_done", snoop_done, 0);
        check_val("rst_hit", snoop_hit, 0);
        check_val("rst_wb_addr", wb_addr, 0);
        check_val("rst_wb_data", wb_data, 0);
        check_val("rst_line_state", line_state, 0);

        // Miss on an empty cache.
        do_snoop(2'b01, 8'h05, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp1_hit", h, 0);
        check_val("tp1_ls", ls, 0);
        check_val("tp1_lat", lat, 2);

        // Shared line hit by write miss drops to I.
        cpu_write(8'h05, 2'b01, 8'h11);
        do_snoop(2'b10, 8'h05, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp2_hit", h, 1);
        check_val("tp2_ls", ls, 2'b01);
        do_snoop(2'b01, 8'h05, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp2_resnoop_hit", h, 0);

        // Modified read miss: writeback with 3 cycles of stall.
        cpu_write(8'h0A, 2'b10, 8'h3C);
        do_snoop(2'b01, 8'h0A, 3, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp3_hit", h, 1);
        check_val("tp3_ls", ls, 2'b10);
        check_val("tp3_lat", lat, 5);
        do_snoop(2'b01, 8'h0A, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp3_after_ls", ls, 2'b01);

        // Same index, different tag: miss, line untouched.
        cpu_write(8'h0A, 2'b10, 8'h3C);
        do_snoop(2'b01, 8'h1A, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp4_hit", h, 0);
        check_val("tp4_lat", lat, 2);
        do_snoop(2'b11, 8'h0A, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp4_still_m", ls, 2'b10);
        check_val("tp4_inv_lat", lat, 2);

        // CPU write to the line mid-writeback lands after the snoop's downgrade.
        cpu_write(8'h0A, 2'b10, 8'h3C);
        do_snoop(2'b10, 8'h0A, 3, 3, 8'h0A, 2'b01, 8'h77, h, ls, lat);
        check_val("tp5_hit", h, 1);
        do_snoop(2'b01, 8'h0A, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("tp5_final_hit", h, 1);
        check_val("tp5_final_ls", ls, 2'b01);

        // bus_op 00 with valid is ignored.
        bus_valid = 1'b1; bus_op = 2'b00; bus_addr = 8'h05;
        @(negedge Clock);
        check_val("nop_ready", bus_ready, 1);
        @(negedge Clock);
        bus_valid = 1'b0;
        check_val("nop_done", snoop_done, 0);
        check_val("nop_ready2", bus_ready, 1);

        // Exclusive encoding.
        cpu_write(8'h07, 2'b11, 8'h12);
        do_snoop(2'b01, 8'h07, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("e_hit", h, mesi);
        check_val("e_ls", ls, mesi ? 2'b11 : 2'b00);

        // Reset in the middle of a writeback.
        cpu_write(8'h0A, 2'b10, 8'h5A);
        bus_valid = 1'b1; bus_op = 2'b01; bus_addr = 8'h0A; wb_ready = 1'b0;
        @(negedge Clock);
        bus_valid = 1'b0; bus_op = 2'b00;
        @(negedge Clock);
        check_val("rstwb_in_wb", wb_valid, 1);
        #2 Resetn = 1'b0;
        #1;
        check_val("rstwb_wb_valid", wb_valid, 0);
        check_val("rstwb_abort", abort_mem, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        model_clear();
        @(negedge Clock);
        check_val("rstwb_ready", bus_ready, 1);
        do_snoop(2'b01, 8'h0A, 1, 0, 8'h00, 2'b00, 8'h00, h, ls, lat);
        check_val("rstwb_line_i", ls, 2'b00);

        // Randomized traffic against the reference cache.
        for (int it = 0; it < 200; it++) begin
            logic [7:0] a, ca;
            logic [1:0] op;
            int         cn;
            if ($urandom_range(0, 1) == 1)
                cpu_write(8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 8'($urandom));
            a  = 8'($urandom_range(0, 15));
            op = 2'($urandom_range(1, 3));
            cn = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : 0;
            ca = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 15));
            do_snoop(op, a, int'($urandom_range(1, 4)), cn, ca, 2'($urandom_range(0, 3)),
                     8'($urandom), h, ls, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snoop_listener_array.md
Name: snoop_listener_array

Overview:
- Clocked, parametrised successor of the combinational MSI listener.
- Holds per-line coherence state, tag and data for a direct-mapped cache of 2^INDEX_W lines, and serves one snooped bus transaction at a time.
- On a Modified hit it runs a writeback handshake toward memory and asserts memory-abort; CPU-side controller fills and updates lines via a separate port.
- Sits between the shared bus and the local cache controller.

Parameters:
ADDR_W, 8, bus/CPU address width
INDEX_W, 2, index bits; NUM_LINES = 2^INDEX_W
DATA_W, 8, line data width

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
bus_valid  input  1  snoop request present
bus_ready  output  1  listener can accept snoop (high only in IDLE)
bus_op  input  2  01 read miss, 10 write miss, 11 invalidate, 00 none
bus_addr  input  ADDR_W  snooped address; low INDEX_W bits = index, rest = tag
cpu_we  input  1  local line write (fill/state change)
cpu_addr  input  ADDR_W  line address for cpu_we
cpu_state  input  2  new state: 00 I, 01 S, 10 M (11 E only with macro)
cpu_data  input  DATA_W  line data for cpu_we
wb_valid  output  1  writeback data valid
wb_ready  input  1  memory accepts writeback
wb_addr  output  ADDR_W  writeback address
wb_data  output  DATA_W  writeback data
abort_mem  output  1  memory must abort its response to the current bus op
snoop_done  output  1  one-cycle pulse: snoop finished
snoop_hit  output  1  valid with snoop_done: tag match and state != I
line_state  output  2  state of indexed line before update, valid with snoop_done

Behaviour:
- Reset (Resetn low, async): all line states 00 (I), tags/data 0, FSM IDLE; bus_ready=1 after reset release; wb_valid, abort_mem, snoop_done, snoop_hit=0; wb_addr, wb_data, line_state=0.
- FSM states: IDLE, LOOKUP, WRITEBACK, UPDATE.
- IDLE: bus_ready=1. Accept on bus_valid && bus_op!=00; latch op and address; go LOOKUP. bus_op=00 with bus_valid is ignored.
- LOOKUP (1 cycle): hit = tag match && state!=I.
  - Miss, or hit state S/E: go UPDATE.
  - Hit state M with op 01 or 10: go WRITEBACK.
  - Hit state M with op 11: go UPDATE, no writeback. Invalidate is illegal against M; the line drops to I.
- WRITEBACK: wb_valid=1, abort_mem=1, wb_addr=latched address, wb_data=line data.
  - Held stable until wb_ready is sampled high, then go UPDATE.
  - No timeout.
- UPDATE (1 cycle): write next state, only when hit.
  - S: 11→I, 10→I, 01→S.
  - M: 01→S, 10→I, 11→I.
  - Pulse snoop_done with snoop_hit and line_state (pre-update state); return IDLE.
  - abort_mem stays high through UPDATE if a writeback occurred.
- Latency: non-writeback snoop gives snoop_done 2 cycles after acceptance; writeback snoop gives 2 + writeback-wait cycles.
- cpu_we: writes state/tag/data of the indexed line on the clock edge, in any FSM state.
- Conflict: cpu_we targets the line the current snoop is processing (LOOKUP through UPDATE).
  - CPU write is deferred one cycle past UPDATE.
  - Only one deferred write is held; a second cpu_we during deferral overwrites it.
- Reset mid-operation: FSM returns to IDLE and all lines to I. Any writeback in progress is dropped; wb_valid falls asynchronously.
- cpu_state=11 without the macro is stored as I.

Optional Feature:
- Macro: SNOOP_MESI_EXCLUSIVE_EN.
- Defined: state 11 = Exclusive (clean, sole copy).
  - E + 01 → S, no writeback.
  - E + 10 → I.
  - E + 11 → I.
  - abort_mem=1 for one UPDATE cycle on an E hit with op 01 (cache-to-cache supply indication).
- Undefined: three-state MSI; 11 writes coerced to I.

Test Plan:
- Reset, then snoop op 01 at addr 0x05 → snoop_done 2 cycles after accept, snoop_hit=0, line_state=00, no wb_valid.
- cpu_we addr 0x05, state 01; snoop op 10 at 0x05 → snoop_hit=1, line_state=01, line becomes I (re-snoop shows hit=0).
- cpu_we addr 0x0A, state 10, data 0x3C; snoop op 01 at 0x0A with wb_ready held low 3 cycles → wb_valid/abort_mem high, wb_addr=0x0A, wb_data=0x3C stable; done 5 cycles after accept; state becomes 01.
- Tag mismatch: line 0x0A in M; snoop 0x1A (same index) → hit=0, no writeback, line stays M.
- Conflict: during WRITEBACK, cpu_we on the same line with state 01 → snoop update applied first (I for op 10), then CPU write gives final state 01.
- Resetn low in WRITEBACK → wb_valid and abort_mem fall immediately, all lines I, bus_ready=1 after release.
